// File: rtl/stream_demux_if.sv
// Purpose: handshake/bus bundle between a single stream source and a stream_demux's output channels.
// Latency: none (wires only).
// Backpressure: carries in_ready upstream and per-channel out_ready from the consumers.
// Ports: in_valid/in_ready/in_data/in_sel (source side), out_valid/out_ready/out_data (consumer side).
// Modports: master = source + consumers (testbench/parent view), slave = the demux itself.
interface stream_demux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/stream_demux.sv
// Purpose: registered 1-to-N stream demux; one holding register per output channel, out-of-range selects are discarded.
// Latency: one cycle from input acceptance to out_valid/out_data; a held beat can be popped on the following edge.
// Backpressure: in_ready is the selected channel's (empty | out_ready); a stalled full channel blocks the input (head-of-line).
// Ports: clk, rst_n (async assert, active-low), bus (stream_demux_if.slave),
//        drop_count (16-bit saturating discard counter, only when STREAM_DEMUX_DROP_CNT_EN is defined).
// Option macro: STREAM_DEMUX_DROP_CNT_EN.
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_demux_if.slave       bus
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  localparam int SEL_W = $clog2(CHANNELS);

  // Per-channel holding register.
  logic [CHANNELS-1:0]            v;
  logic [CHANNELS-1:0][WIDTH-1:0] d;

  // One-hot decode of in_sel; all-zero means an out-of-range select.
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] load;
  logic                sel_free;

  always_comb begin
    sel_hit  = '0;
    // An illegal select finds no channel and leaves sel_free at 1, so it is always accepted.
    sel_free = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.in_sel == SEL_W'(c)) begin
        sel_hit[c] = 1'b1;
        sel_free   = ~v[c] | bus.out_ready[c];
      end
    end
  end

  assign bus.in_ready = sel_free;
  assign load         = sel_hit & {CHANNELS{bus.in_valid & sel_free}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      d <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (load[c]) begin
          // Covers the same-cycle pop+load case too: valid stays set, no bubble.
          v[c] <= 1'b1;
          d[c] <= bus.in_data;
        end else if (bus.out_ready[c]) begin
          // Data is left in place after a pop; only the valid bit drops.
          v[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = v;
  assign bus.out_data  = d;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic drop_xfer;

  // in_ready is 1 for illegal selects, so in_valid alone completes the transfer.
  assign drop_xfer = bus.in_valid & ~|sel_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop_xfer && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Purpose: directed self-checking bench for stream_demux (WIDTH=8, CHANNELS=3).
// Latency: n/a.
// Backpressure: n/a.
module tb_stream_demux;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stream_demux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  stream_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with a beat presented: nothing may load.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.in_sel    = 2'd0;
    bus.out_ready = 3'b000;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("rst_drop_count", 32'(drop_count), 32'h0);
`endif
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);

    // Basic route to channel 2 with consumer stalled.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_sel   = 2'd2;
    #1;
    chk("route_in_ready_empty", 32'(bus.in_ready), 32'h1);
    tick();
    chk("route_out_valid", 32'(bus.out_valid), 32'h4);
    chk("route_ch2_data",  32'(bus.out_data[23:16]), 32'hA5);
    bus.in_data = 8'h3C;
    #1;
    chk("route_in_ready_full", 32'(bus.in_ready), 32'h0);
    tick();
    chk("route_stall_valid", 32'(bus.out_valid), 32'h4);
    chk("route_stall_data",  32'(bus.out_data[23:16]), 32'hA5);
    bus.out_ready = 3'b100;
    #1;
    chk("route_in_ready_passthru", 32'(bus.in_ready), 32'h1);
    tick();
    chk("route_second_valid", 32'(bus.out_valid), 32'h4);
    chk("route_second_data",  32'(bus.out_data[23:16]), 32'h3C);
    bus.in_valid = 1'b0;
    tick();
    chk("route_drained", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 3'b000;

    // Back-to-back stream on channel 1 with all consumers ready.
    bus.out_ready = 3'b111;
    bus.in_sel    = 2'd1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      #1;
      chk("b2b_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      chk("b2b_out_valid", 32'(bus.out_valid), 32'h2);
      chk("b2b_ch1_data",  32'(bus.out_data[15:8]), 32'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_drained", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 3'b000;

    // Simultaneous pop and load on channel 0.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    bus.in_sel   = 2'd0;
    tick();
    chk("popload_setup_valid", 32'(bus.out_valid), 32'h1);
    chk("popload_setup_data",  32'(bus.out_data[7:0]), 32'h11);
    bus.out_ready = 3'b001;
    bus.in_data   = 8'h22;
    #1;
    chk("popload_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("popload_valid", 32'(bus.out_valid), 32'h1);
    chk("popload_data",  32'(bus.out_data[7:0]), 32'h22);
    bus.in_valid  = 1'b0;
    bus.out_ready = 3'b000;

    // Isolation: channel 0 full and stalled, channel 1 still accepts.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_sel   = 2'd1;
    #1;
    chk("iso_in_ready_ch1", 32'(bus.in_ready), 32'h1);
    tick();
    chk("iso_out_valid", 32'(bus.out_valid), 32'h3);
    chk("iso_ch1_data",  32'(bus.out_data[15:8]), 32'h55);
    chk("iso_ch0_data",  32'(bus.out_data[7:0]), 32'h22);
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    #1;
    chk("iso_hol_block", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 3'b010;
    tick();
    chk("iso_pop_ch1_valid", 32'(bus.out_valid), 32'h1);
    chk("iso_pop_ch0_data",  32'(bus.out_data[7:0]), 32'h22);
    bus.out_ready = 3'b000;

    // Illegal select: three discarded beats.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    bus.in_sel   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("illegal_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
    end
    chk("illegal_out_valid", 32'(bus.out_valid), 32'h1);
    chk("illegal_out_data",  32'(bus.out_data), 32'h3C5522);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("illegal_drop_3", 32'(drop_count), 32'd3);
    // 65532 more reaches exactly 65535, then 5 more must saturate (65540 total).
    repeat (65532) @(posedge clk);
    #1;
    chk("drop_at_max", 32'(drop_count), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_saturated", 32'(drop_count), 32'hFFFF);
`endif
    bus.in_valid = 1'b0;

    // Mid-operation reset clears held beats immediately.
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_out_data",  32'(bus.out_data),  32'h0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("midrst_drop_count", 32'(drop_count), 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h6E;
    bus.in_sel   = 2'd2;
    tick();
    chk("after_rst_valid", 32'(bus.out_valid), 32'h4);
    chk("after_rst_data",  32'(bus.out_data[23:16]), 32'h6E);
    bus.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready flow control. It routes each input beat to the output channel named by `in_sel`, and holds it in a one-entry register per channel until that channel's consumer accepts it. It replaces the plain combinational demux wherever the downstream consumers can stall independently. Beats with out-of-range selects are consumed and discarded.

## Interface
Parameters:
- `WIDTH`, 8, data bits per beat (≥1)
- `CHANNELS`, 4, number of output channels (≥2)
- `SEL_W`, derived localparam, `$clog2(CHANNELS)`, not overridable

Ports:
- `clk`  in  1  sole clock; all state is on the rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  input beat accepted this cycle when high together with `in_valid`
- `in_data`  in  WIDTH  input payload
- `in_sel`  in  SEL_W  destination channel index
- `out_valid`  out  CHANNELS  bit c: channel c register holds a beat
- `out_ready`  in  CHANNELS  bit c: channel c consumer accepts
- `out_data`  out  CHANNELS*WIDTH  channel c payload at `[c*WIDTH +: WIDTH]`
- `drop_count`  out  16  saturating count of discarded beats; present only with `STREAM_DEMUX_DROP_CNT_EN`

## Operation
- Each channel c has a one-entry register made of a valid bit `v[c]` and a data word `d[c]`. `out_valid[c] = v[c]` and the channel's slice of `out_data` equals `d[c]`.
- Legal select (`in_sel < CHANNELS`): `in_ready = ~v[in_sel] | out_ready[in_sel]`. This is combinational and passes ready through from the selected channel.
- Illegal select (`in_sel >= CHANNELS`, possible only when CHANNELS is not a power of two): `in_ready = 1`. The beat is accepted and discarded, and no channel changes.
- Input transfer: `in_valid & in_ready`. On a legal transfer, `d[in_sel] <= in_data` and `v[in_sel] <= 1`.
- Output pop on channel c: `v[c] & out_ready[c]`. If there is no load on the same edge, `v[c] <= 0`. `d[c]` holds its value after a pop.
- Pop and load on the same channel in the same cycle: the new data is loaded and `v[c]` stays 1. No bubble appears and no beat is lost.
- Channels are independent. A pop on one channel never affects another.
- Head-of-line rule: a full, stalled selected channel blocks the input, even if other channels are free.
- Source obligation: while `in_valid & ~in_ready`, `in_valid`, `in_data` and `in_sel` stay stable. Violations are undefined.
- `out_ready[c]` while `v[c]=0` has no effect.

## Timing
- Reset (`rst_n=0`, asynchronous) sets `out_valid` to all zeros, `out_data` to all zeros and `drop_count` to 0. `in_ready` follows its combinational equation, so it reads 1 while in reset.
- Reset mid-operation: all held beats are lost immediately. Release is synchronous to the next `clk` edge, and the block is usable on the first edge after release.
- Latency: a beat accepted at edge k is visible on `out_valid`/`out_data` after edge k. It can be popped at edge k+1 at the earliest.
- Throughput: one beat per cycle per selected channel when `out_ready` is held high.
- The only combinational paths are `in_sel`/`out_ready`/`out_valid` to `in_ready`. No input reaches `out_data` without a register.

## Configuration
- `STREAM_DEMUX_DROP_CNT_EN` defined:
  - The `drop_count` port exists.
  - It increments by 1 on each illegal-select transfer and saturates at 0xFFFF.
  - It is cleared only by reset.
- Macro undefined: the port and counter are absent, and illegal beats are dropped silently.
- In both cases, when CHANNELS is a power of two no illegal selects exist and `drop_count` stays 0.

## Test plan
All scenarios use WIDTH=8, CHANNELS=3 and the macro defined.
- **Reset:** hold `rst_n=0` with `in_valid=1`. Expect `out_valid=3'b000`, `out_data=0`, `drop_count=0` and no load.
- **Basic route:** send 0xA5 with sel=2 while `out_ready=0`. After one edge expect `out_valid=3'b100` and channel 2 data 0xA5. A second beat 0x3C with sel=2 then sees `in_ready=0` until `out_ready[2]=1`.
- **Back-to-back:** keep `out_ready=3'b111` and stream 0x01..0x10 with sel=1. Expect 16 beats on channel 1 in order, one per cycle, with `in_ready` constantly 1.
- **Simultaneous pop and load:**
  - Setup: channel 0 holds 0x11 and `out_ready[0]=1`.
  - Stimulus: in the same cycle, send 0x22 with sel=0.
  - Expected: 0x11 is consumed, then channel 0 shows 0x22 with `out_valid[0]` staying 1.
- **Isolation:** stall channel 0 while it is full, then send 0x55 with sel=1. Expect it accepted and channel 0 unchanged.
- **Illegal select:** send 3 beats with sel=3. Expect `in_ready=1`, `out_valid` unchanged and `drop_count=3`. Force 65540 drops and expect `drop_count=0xFFFF`.
